// File: rtl/sram_1p_access_ctrl_if.sv
// Requester-side bus of the single-port SRAM access controller:
// write request channel, read request channel and read response channel.
interface sram_1p_access_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 152
);
  // write request channel
  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] w_mask;

  // read request channel
  logic              r_req_valid;
  logic              r_req_ready;
  logic [ADDR_W-1:0] r_req_addr;

  // read response channel
  logic              r_resp_valid;
  logic              r_resp_ready;
  logic [DATA_W-1:0] r_resp_data;

  // pipeline logic issuing requests and consuming responses
  modport master (
    output w_valid, w_addr, w_data, w_mask,
    input  w_ready,
    output r_req_valid, r_req_addr,
    input  r_req_ready,
    input  r_resp_valid, r_resp_data,
    output r_resp_ready
  );

  // the access controller
  modport slave (
    input  w_valid, w_addr, w_data, w_mask,
    output w_ready,
    input  r_req_valid, r_req_addr,
    output r_req_ready,
    output r_resp_valid, r_resp_data,
    input  r_resp_ready
  );
endinterface

// File: rtl/sram_1p_access_ctrl.sv
// Requester-side controller for a single-port SRAM macro with 1-cycle read
// latency. Zero-fills the array after reset, then arbitrates independent
// write and read streams onto the one RW port, returning read data through
// a valid/ready channel backed by a single-entry hold register.
module sram_1p_access_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int DATA_W = 152
) (
  input  logic              clock,
  input  logic              reset_n,
  sram_1p_access_ctrl_if.slave req,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [DATA_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    RS_EMPTY = 2'd0,
    RS_PASS  = 2'd1,
    RS_HELD  = 2'd2
  } resp_state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam logic              GRANT_READ  = 1'b0;
  localparam logic              GRANT_WRITE = 1'b1;

  ctrl_state_e       state_q;
  logic [ADDR_W-1:0] init_ptr_q;
  logic              init_done_q;

  resp_state_e       resp_q;
  resp_state_e       resp_d;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] hold_d;
  logic              last_grant_q;
  logic              last_grant_d;

  logic              run_s;
  logic              resp_taken_s;
  logic              read_ok_s;
  logic              conflict_s;
  logic              grant_w_s;
  logic              grant_r_s;

  // Control FSM: BOOT for one cycle, INIT sweeps every address, RUN forever.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_BOOT;
      init_ptr_q  <= {ADDR_W{1'b0}};
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q     <= ST_INIT;
          init_ptr_q  <= {ADDR_W{1'b0}};
          init_done_q <= 1'b0;
        end
        ST_INIT: begin
          init_ptr_q <= init_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (init_ptr_q == LAST_ADDR) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            state_q     <= ST_INIT;
            init_done_q <= 1'b0;
          end
        end
        ST_RUN: begin
          state_q     <= ST_RUN;
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_BOOT;
          init_ptr_q  <= {ADDR_W{1'b0}};
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Arbitration: a read is eligible only when the response slot frees up
  // this cycle; true conflicts alternate, starting with the write.
  always_comb begin
    run_s        = (state_q == ST_RUN);
    resp_taken_s = (resp_q != RS_EMPTY) & req.r_resp_ready;
    read_ok_s    = run_s & ((resp_q == RS_EMPTY) | resp_taken_s);
    conflict_s   = req.w_valid & req.r_req_valid & read_ok_s;
    if (conflict_s) begin
      grant_w_s    = (last_grant_q == GRANT_READ);
      grant_r_s    = (last_grant_q == GRANT_WRITE);
      last_grant_d = (last_grant_q == GRANT_READ) ? GRANT_WRITE : GRANT_READ;
    end else begin
      grant_w_s    = run_s & req.w_valid;
      grant_r_s    = read_ok_s & req.r_req_valid;
      last_grant_d = last_grant_q;
    end
  end

  assign req.w_ready     = grant_w_s;
  assign req.r_req_ready = grant_r_s;

  // SRAM port drive: init zero-fill, the granted request, or idle zeros.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = {ADDR_W{1'b0}};
    sram_wmask = {DATA_W{1'b0}};
    sram_wdata = {DATA_W{1'b0}};
    case (state_q)
      ST_INIT: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_ptr_q;
        sram_wmask = {DATA_W{1'b1}};
        sram_wdata = {DATA_W{1'b0}};
      end
      ST_RUN: begin
        if (grant_w_s) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = req.w_addr;
          sram_wmask = req.w_mask;
          sram_wdata = req.w_data;
        end else if (grant_r_s) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b0;
          sram_addr  = req.r_req_addr;
        end else begin
          sram_en    = 1'b0;
        end
      end
      ST_BOOT: begin
        sram_en = 1'b0;
      end
      default: begin
        sram_en = 1'b0;
      end
    endcase
  end

  // Response slot next state: a fresh read always lands in PASS; an untaken
  // PASS snapshots the macro output so later writes cannot disturb it.
  always_comb begin
    resp_d = resp_q;
    hold_d = hold_q;
    if (grant_r_s) begin
      resp_d = RS_PASS;
    end else begin
      case (resp_q)
        RS_PASS: begin
          if (resp_taken_s) begin
            resp_d = RS_EMPTY;
          end else begin
            resp_d = RS_HELD;
            hold_d = sram_rdata;
          end
        end
        RS_HELD: begin
          if (resp_taken_s) begin
            resp_d = RS_EMPTY;
          end else begin
            resp_d = RS_HELD;
          end
        end
        RS_EMPTY: begin
          resp_d = RS_EMPTY;
        end
        default: begin
          resp_d = RS_EMPTY;
        end
      endcase
    end
  end

  // Response slot, hold register and arbitration history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_q       <= RS_EMPTY;
      hold_q       <= {DATA_W{1'b0}};
      last_grant_q <= GRANT_READ;
    end else begin
      resp_q       <= resp_d;
      hold_q       <= hold_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req.r_resp_valid = (resp_q != RS_EMPTY);
  assign req.r_resp_data  = (resp_q == RS_PASS) ? sram_rdata : hold_q;
  assign init_done        = init_done_q;

endmodule

// File: tb/tb_sram_1p_access_ctrl.sv
// Randomised bench for sram_1p_access_ctrl: a behavioural SRAM macro, a
// shadow-memory/response-queue reference model and directed scenarios.
module tb_sram_1p_access_ctrl;
  localparam int AW = 7;
  localparam int DW = 152;
  localparam int DEPTH = 128;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          init_done;
  logic [AW-1:0] sram_addr;
  logic          sram_en;
  logic          sram_wmode;
  logic [DW-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  sram_1p_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_1p_access_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (bus),
    .init_done  (init_done),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clock = ~clock;

  // behavioural SRAM macro, 1-cycle read latency, per-bit write mask
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= (sram_wmask & sram_wdata) | (~sram_wmask & mem[sram_addr]);
      else            sram_rdata     <= mem[sram_addr];
    end
  end

  // reference model
  logic [DW-1:0] shadow [0:DEPTH-1];
  logic [DW-1:0] exp_q [$];
  logic          last_conf_w;
  logic          model_run;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.w_valid      = 1'b0;
    bus.w_addr       = 7'd0;
    bus.w_data       = {DW{1'b0}};
    bus.w_mask       = {DW{1'b0}};
    bus.r_req_valid  = 1'b0;
    bus.r_req_addr   = 7'd0;
    bus.r_resp_ready = 1'b1;
  endtask

  task automatic set_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    bus.w_valid = 1'b1;
    bus.w_addr  = a;
    bus.w_data  = d;
    bus.w_mask  = m;
  endtask

  task automatic set_read(input logic [AW-1:0] a);
    bus.r_req_valid = 1'b1;
    bus.r_req_addr  = a;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_w_ready"},   bus.w_ready, 0);
    check_eq({tag, "_r_ready"},   bus.r_req_ready, 0);
    check_eq({tag, "_rv"},        bus.r_resp_valid, 0);
    check_eq({tag, "_rdata"},     bus.r_resp_data, 0);
    check_eq({tag, "_init_done"}, init_done, 0);
    check_eq({tag, "_en"},        sram_en, 0);
    check_eq({tag, "_addr"},      sram_addr, 0);
    check_eq({tag, "_wmode"},     sram_wmode, 0);
    check_eq({tag, "_wmask"},     sram_wmask, 0);
    check_eq({tag, "_wdata"},     sram_wdata, 0);
  endtask

  // One RUN cycle: inputs were set at posedge+1; predict, compare, then
  // advance the model across the next posedge. Returns at posedge+1.
  task automatic cycle_check();
    logic rv, rok, conf, gw, gr;
    #1;
    rv   = (exp_q.size() != 0);
    rok  = model_run && (!rv || bus.r_resp_ready);
    conf = bus.w_valid && bus.r_req_valid && rok;
    gw   = model_run && bus.w_valid && !(conf && last_conf_w);
    gr   = rok && bus.r_req_valid && !gw;
    check_eq("init_done", init_done, model_run);
    check_eq("w_ready", bus.w_ready, gw);
    check_eq("r_req_ready", bus.r_req_ready, gr);
    check_eq("r_resp_valid", bus.r_resp_valid, rv);
    check_eq("sram_en", sram_en, gw || gr);
    if (rv) check_eq("r_resp_data", bus.r_resp_data, exp_q[0]);
    if (gw) begin
      check_eq("wr_addr", sram_addr, bus.w_addr);
      check_eq("wr_wmode", sram_wmode, 1);
      check_eq("wr_wdata", sram_wdata, bus.w_data);
      check_eq("wr_wmask", sram_wmask, bus.w_mask);
    end
    if (gr) begin
      check_eq("rd_addr", sram_addr, bus.r_req_addr);
      check_eq("rd_wmode", sram_wmode, 0);
    end
    @(posedge clock);
    if (gw) shadow[bus.w_addr] = (bus.w_mask & bus.w_data) | (~bus.w_mask & shadow[bus.w_addr]);
    if (rv && bus.r_resp_ready) void'(exp_q.pop_front());
    if (gr) exp_q.push_back(shadow[bus.r_req_addr]);
    if (conf) last_conf_w = gw;
    #1;
  endtask

  // Reset, release, then follow the zero-fill sweep; abort_ptr >= 0 drops
  // reset again while that address is being written.
  task automatic reset_and_init(input int abort_ptr);
    bus.w_valid      = 1'b1;
    bus.r_req_valid  = 1'b1;
    bus.r_resp_ready = 1'b1;
    bus.w_addr       = 7'd1;
    bus.r_req_addr   = 7'd2;
    bus.w_data       = rand_word();
    bus.w_mask       = {DW{1'b1}};
    reset_n = 1'b0;
    exp_q.delete();
    last_conf_w = 1'b0;
    model_run   = 1'b0;
    @(posedge clock);
    #1;
    check_quiet("rst");
    reset_n = 1'b1;
    #1;
    check_eq("boot_en", sram_en, 0);
    check_eq("boot_init_done", init_done, 0);
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clock);
      #1;
      if (k == abort_ptr) begin
        reset_n = 1'b0;
        #1;
        check_quiet("midrst");
        return;
      end
      check_eq("init_en", sram_en, 1);
      check_eq("init_addr", sram_addr, k[AW-1:0]);
      check_eq("init_wmode", sram_wmode, 1);
      check_eq("init_wmask", sram_wmask, {DW{1'b1}});
      check_eq("init_wdata", sram_wdata, 0);
      check_eq("init_w_ready", bus.w_ready, 0);
      check_eq("init_r_ready", bus.r_req_ready, 0);
      check_eq("init_done_low", init_done, 0);
    end
    @(posedge clock);
    #1;
    check_eq("init_done_high", init_done, 1);
    model_run = 1'b1;
    for (int i = 0; i < DEPTH; i++) shadow[i] = {DW{1'b0}};
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] <= rand_word();
    set_idle();

    // reset-abort mid-INIT, then a full clean initialisation
    reset_and_init(60);
    reset_and_init(-1);

    // write addr 5 with 0xA5 under mask 0xFF, read it back
    set_idle(); set_write(7'd5, 152'h1234_00A5, 152'hFF); cycle_check();
    set_idle(); set_read(7'd5); cycle_check();
    set_idle(); #1; check_eq("a5_direct", bus.r_resp_data, 152'hA5); cycle_check();

    // read addr 3, stall the response 3 cycles while re-requesting
    set_idle(); set_write(7'd3, 152'h3C3C, {DW{1'b1}}); cycle_check();
    set_idle(); set_read(7'd3); bus.r_resp_ready = 1'b0; cycle_check();
    for (int i = 0; i < 3; i++) begin
      set_idle(); set_read(7'd3); bus.r_resp_ready = 1'b0; cycle_check();
    end
    set_idle(); set_read(7'd3); cycle_check();
    set_idle(); cycle_check();

    // both streams saturated: alternating grants
    for (int i = 0; i < 8; i++) begin
      set_idle();
      set_write(7'($urandom_range(0, 7)), rand_word(), rand_word());
      set_read(7'($urandom_range(0, 7)));
      cycle_check();
    end
    set_idle(); cycle_check();

    // stalled response must not see a later same-address write
    set_idle(); set_write(7'd9, 152'h11, {DW{1'b1}}); cycle_check();
    set_idle(); set_read(7'd9); bus.r_resp_ready = 1'b0; cycle_check();
    set_idle(); set_write(7'd9, 152'h22, {DW{1'b1}}); bus.r_resp_ready = 1'b0; cycle_check();
    set_idle(); bus.r_resp_ready = 1'b0; #1; check_eq("held_old", bus.r_resp_data, 152'h11); cycle_check();
    set_idle(); cycle_check();
    set_idle(); set_read(7'd9); cycle_check();
    set_idle(); #1; check_eq("new_after", bus.r_resp_data, 152'h22); cycle_check();

    // randomised traffic over a narrow address window
    for (int i = 0; i < 1500; i++) begin
      bus.w_valid      = ($urandom_range(0, 99) < 50);
      bus.w_addr       = 7'($urandom_range(0, 15));
      bus.w_data       = rand_word();
      bus.w_mask       = ($urandom_range(0, 3) == 0) ? {DW{1'b1}} : rand_word();
      bus.r_req_valid  = ($urandom_range(0, 99) < 55);
      bus.r_req_addr   = 7'($urandom_range(0, 15));
      bus.r_resp_ready = ($urandom_range(0, 99) < 60);
      cycle_check();
    end
    set_idle(); cycle_check();
    set_idle(); cycle_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
